// File: rtl/shift_pkg.sv
// Shared types and constants for the serial shift transmitter.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Loadable down-counter that tracks the bits still to send for the word in flight.
module shift_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero_next
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] bit_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= CW'(WIDTH);
        end else if (dec) begin
            bit_cnt <= bit_cnt - CW'(1);
        end
    end

    // The FSM leaves SHIFT on the beat taken at a count of one, so the counter never wraps.
    assign zero_next = (bit_cnt == CW'(1));

endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-to-serial transmitter: loads a word by handshake, streams it MSB- or LSB-first.
module serial_shift_tx
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             done
);

    tx_state_t        state;
    logic [WIDTH-1:0] shift_reg;
    logic             dir_q;
    logic             load_fire;
    logic             beat;
    logic             zero_next;
    logic             last_beat;

    assign load_ready = (state == IDLE);
    assign ser_valid  = (state == SHIFT);
    assign load_fire  = load_valid & load_ready;
    assign beat       = ser_valid & ser_ready;
    assign last_beat  = beat & zero_next;

    shift_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load_fire),
        .dec      (beat),
        .zero_next(zero_next)
    );

    // NOTE: every register here is cleared by the async reset so a mid-word abort leaves no residue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (load_fire) state <= SHIFT;
                SHIFT:   if (last_beat) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            dir_q     <= DIR_LEFT;
        end else if (load_fire) begin
            shift_reg <= data_in;
            dir_q     <= dir;
        end else if (beat) begin
            if (dir_q == DIR_RIGHT) begin
                shift_reg <= shift_reg >> 1;
            end else begin
                shift_reg <= shift_reg << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= last_beat;
        end
    end

    // Forced low outside SHIFT so a stale register bit never leaks onto the line.
    assign ser_out = ser_valid & ((dir_q == DIR_RIGHT) ? shift_reg[0] : shift_reg[WIDTH-1]);

endmodule

// File: tb/tb_serial_shift_tx.sv
// Self-checking bench: directed and randomized words checked against a bit-queue reference model.
module tb_serial_shift_tx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] data_in = '0;
    logic             dir = 1'b0;
    logic             ser_valid;
    logic             ser_ready = 1'b0;
    logic             ser_out;
    logic             done;

    int checks = 0;
    int errors = 0;

    serial_shift_tx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .data_in   (data_in),
        .dir       (dir),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_out   (ser_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ser_valid"}, ser_valid, 1'b0);
        check({tag, "_ser_out"}, ser_out, 1'b0);
        check({tag, "_load_ready"}, load_ready, 1'b1);
    endtask

    // stall_mode: 0 none, 1 three-cycle stall before the third bit, 2 random ready.
    // noise: hold load_valid with fresh data and toggle dir while the word is in flight.
    // chain: leave straight after the done cycle so the next word loads during it.
    task automatic send_word(input logic [WIDTH-1:0] word, input logic d,
                             input int stall_mode, input bit noise, input bit chain);
        logic q[$];
        int   cycles;
        int   sent;
        int   stall_left;
        int   wait_cnt;
        logic rdy;

        wait_cnt = 0;
        while (load_ready !== 1'b1 && wait_cnt < 20) begin
            next_cycle();
            wait_cnt++;
        end
        check("load_ready_before_load", load_ready, 1'b1);

        for (int i = 0; i < WIDTH; i++) begin
            q.push_back(d ? word[i] : word[WIDTH-1-i]);
        end

        data_in    = word;
        dir        = d;
        load_valid = 1'b1;
        next_cycle();
        load_valid = noise;
        if (noise) data_in = WIDTH'($urandom);

        cycles     = 0;
        sent       = 0;
        stall_left = 3;
        while (q.size() > 0 && cycles < 200) begin
            case (stall_mode)
                1:       rdy = !(sent == 2 && stall_left > 0);
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            if (!rdy && stall_mode == 1) stall_left--;
            ser_ready = rdy;
            check("ser_valid_shift", ser_valid, 1'b1);
            check($sformatf("ser_out_bit%0d", sent), ser_out, q[0]);
            check("load_ready_shift", load_ready, 1'b0);
            check("done_shift", done, 1'b0);
            if (noise) begin
                dir     = ~dir;
                data_in = WIDTH'($urandom);
            end
            next_cycle();
            if (rdy) begin
                void'(q.pop_front());
                sent++;
            end
            cycles++;
        end
        check_int("bits_sent", sent, WIDTH);
        if (stall_mode == 0) check_int("unstalled_latency", cycles, WIDTH);

        load_valid = 1'b0;
        ser_ready  = 1'b0;
        check("done_pulse", done, 1'b1);
        check_idle("after_word");
        if (!chain) begin
            next_cycle();
            check("done_single_cycle", done, 1'b0);
        end
    endtask

    initial begin
        // Power-on reset, then a reset asserted mid-idle.
        next_cycle();
        next_cycle();
        check_idle("por");
        check("por_done", done, 1'b0);
        reset = 1'b0;
        next_cycle();
        next_cycle();
        check_idle("idle");
        reset = 1'b1;
        #1;
        check_idle("idle_reset");
        check("idle_reset_done", done, 1'b0);
        #2;
        reset = 1'b0;
        next_cycle();

        send_word(4'b1011, 1'b0, 0, 1'b0, 1'b0);
        send_word(4'b1011, 1'b1, 0, 1'b0, 1'b0);
        send_word(4'b1011, 1'b0, 1, 1'b0, 1'b0);
        send_word(4'b0110, 1'b0, 0, 1'b1, 1'b0);
        send_word(4'b1001, 1'b1, 1, 1'b1, 1'b0);
        send_word(4'b1100, 1'b0, 0, 1'b0, 1'b1);
        send_word(4'b0011, 1'b1, 0, 1'b0, 1'b0);

        // Reset mid-word after two beats: the word is abandoned and done never pulses.
        data_in    = 4'b1101;
        dir        = 1'b0;
        load_valid = 1'b1;
        next_cycle();
        load_valid = 1'b0;
        ser_ready  = 1'b1;
        next_cycle();
        next_cycle();
        check("midword_ser_valid", ser_valid, 1'b1);
        reset      = 1'b1;
        load_valid = 1'b1;
        data_in    = 4'b1111;
        #1;
        check_idle("midword_reset");
        check("midword_reset_done", done, 1'b0);
        next_cycle();
        check_idle("reset_ignores_load");
        reset      = 1'b0;
        load_valid = 1'b0;
        ser_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("post_reset_done", done, 1'b0);
            check("post_reset_ser_valid", ser_valid, 1'b0);
        end
        send_word(4'b1101, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            send_word(WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                      1'($urandom), 1'($urandom));
        end
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
